// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and FSM state type for the 4-channel TDM demultiplexer
package tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - bit/slot position tracker for the TDM demux receive frame
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic              last_bit,
    output logic              last_slot,
    output logic              frame_start
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_TOP       = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_AFTER_MSB = CW'(WIDTH - 2);

    // Index of the next expected bit within the current slot, counting down to 0
    logic [CW-1:0] bit_cnt;

    // A load consumes the frame's first bit, so counting resumes one below the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else if (load) begin
            bit_cnt  <= BIT_AFTER_MSB;
            slot_cnt <= '0;
        end else if (step) begin
            if (bit_cnt == '0) begin
                bit_cnt  <= BIT_TOP;
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end else begin
                bit_cnt <= bit_cnt - CW'(1);
            end
        end
    end

    assign last_bit    = (bit_cnt == '0);
    assign last_slot   = (slot_cnt == SLOT_W'(NCH - 1));
    // After a full frame the counters wrap here; a fresh load never lands on this position
    assign frame_start = (bit_cnt == BIT_TOP) && (slot_cnt == '0);

endmodule

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - serial TDM to 4 parallel channels; TDM_DEMUX_PARITY_EN adds a frame parity bit
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sin,
    input  logic                   sin_en,
    input  logic                   fsync,
    output logic [NCH*WIDTH-1:0]   ch_data,
    output logic [NCH-1:0]         ch_valid,
    output logic                   frame_done,
    output logic                   sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic                   par_err
`endif
);

    tdm_state_t        state, state_nxt;
    logic              load, step, deliver, finish, err;
    logic [SLOT_W-1:0] slot_cnt;
    logic              last_bit, last_slot, frame_start;
    logic [WIDTH-2:0]  shift;
    logic [WIDTH-1:0]  slot_word;
    logic [WIDTH-1:0]  ch_reg [NCH];
`ifdef TDM_DEMUX_PARITY_EN
    logic              hold3, par_done, par_acc;
    logic [WIDTH-1:0]  slot3_hold;
`endif

    // The completed slot is the shifted history plus the bit arriving on this edge
    assign slot_word = {shift, sin};

    tdm_slot_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .load        (load),
        .slot_cnt    (slot_cnt),
        .last_bit    (last_bit),
        .last_slot   (last_slot),
        .frame_start (frame_start)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    // Next state and per-bit control; nothing happens on edges without sin_en
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        deliver   = 1'b0;
        finish    = 1'b0;
        err       = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        hold3     = 1'b0;
        par_done  = 1'b0;
`endif
        if (sin_en) begin
            case (state)
                HUNT: begin
                    if (fsync) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        if (fsync) begin
                            load = 1'b1;
                        end else begin
                            err       = 1'b1;
                            state_nxt = HUNT;
                        end
                    end else if (fsync) begin
                        // Unexpected frame start: drop the partial slot and resync on this bit
                        err  = 1'b1;
                        load = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (last_bit) begin
                            if (last_slot) begin
`ifdef TDM_DEMUX_PARITY_EN
                                hold3     = 1'b1;
                                state_nxt = PAR;
`else
                                deliver = 1'b1;
                                finish  = 1'b1;
`endif
                            end else begin
                                deliver = 1'b1;
                            end
                        end
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    state_nxt = RUN;
                    if (fsync) begin
                        err  = 1'b1;
                        load = 1'b1;
                    end else begin
                        par_done = 1'b1;
                    end
                end
`endif
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Serial shift register, advanced on every consumed data bit
    always_ff @(posedge clk) begin
        if (rst)              shift <= '0;
        else if (load | step) shift <= slot_word[WIDTH-2:0];
    end

    // Channel registers and one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) ch_reg[k] <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err    <= 1'b0;
            par_acc    <= 1'b0;
            slot3_hold <= '0;
`endif
        end else begin
            ch_valid   <= '0;
            frame_done <= finish;
            sync_err   <= err;
            if (deliver) begin
                ch_reg[slot_cnt]   <= slot_word;
                ch_valid[slot_cnt] <= 1'b1;
            end
`ifdef TDM_DEMUX_PARITY_EN
            par_err <= 1'b0;
            if (load)      par_acc <= sin;
            else if (step) par_acc <= par_acc ^ sin;
            if (hold3) slot3_hold <= slot_word;
            // Slot 3 is released only once the parity bit has been checked
            if (par_done) begin
                ch_reg[NCH-1]   <= slot3_hold;
                ch_valid[NCH-1] <= 1'b1;
                frame_done      <= 1'b1;
                par_err         <= par_acc ^ sin;
            end
`endif
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign ch_data[g*WIDTH +: WIDTH] = ch_reg[g];
        end
    endgenerate

endmodule
